psum_accum_buffer: RTL and testbench
====================================

PSUM_ACCUM_BUFFER -- requirements
Module: psum_accum_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, psum word width (signed).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, psum address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter REG_WIDTH, default 32, config/status register width.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_conf_ctrl  input  REG_WIDTH  bit0 accumulate enable, bit4 host readback, bit8 clear request.
REQ-007 SHALL have port o_conf_status  output  REG_WIDTH  bit0 busy, bit1 clear done, bit2 overflow (sticky); other bits 0.
REQ-008 SHALL have ports acc_valid/acc_first  input  1  psum beat valid; first beat overwrites instead of adds.
REQ-009 SHALL have ports acc_addr  input  ADDR_WIDTH, and acc_data  input  DATA_WIDTH  target address and signed psum.
REQ-010 SHALL have port acc_ready  output  1  beat accepted when acc_valid and acc_ready are both high.
REQ-011 SHALL have ports host_en  input  1, and host_addr  input  ADDR_WIDTH  host read request.
REQ-012 SHALL have ports host_rdata  output  DATA_WIDTH, and host_rvalid  output  1  host read response.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, ACCUM, DRAIN, HOST.
REQ-014 From IDLE SHALL go to CLEAR on a ctrl[8] 0->1 edge; else HOST if ctrl[4]; else ACCUM if ctrl[0]; priority in that order.
REQ-015 CLEAR SHALL write 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle, then set status bit1 and return to IDLE.
REQ-016 Status bit1 SHALL clear on the next CLEAR entry or reset.
REQ-017 acc_ready SHALL be 1 only in ACCUM.
REQ-018 ACCUM SHALL go to DRAIN when ctrl[0]=0; DRAIN SHALL last until the pipeline is empty (max 2 cycles), then go to IDLE.
REQ-019 Accumulate pipeline: S0 issues the RAM read; S1 gets read data (1-cycle RAM); S2 adds and writes. Write is 2 cycles after acceptance.
REQ-020 The adder SHALL add acc_data to the stored word; with acc_first the stored value SHALL be acc_data.
REQ-021 If S2 writes the address S1 read, S1 SHALL use the S2 result (forwarding), so back-to-back same-address beats accumulate exactly.
REQ-022 Signed add overflow SHALL set status bit2; it stays set until reset or CLEAR entry.
REQ-023 HOST: a host_en pulse SHALL give host_rvalid=1 with the RAM word exactly 2 cycles later; HOST SHALL go to IDLE when ctrl[4]=0 and no read is in flight.
REQ-024 host_en outside HOST SHALL be ignored; no host_rvalid.
REQ-025 In ACCUM, changes to ctrl[4]/ctrl[8] SHALL be ignored until IDLE is reached.
REQ-026 Status bit0 SHALL be 1 in every state except IDLE.

Reset
REQ-027 On rst: state IDLE, acc_ready=0, host_rvalid=0, host_rdata=0, o_conf_status=0, pipeline valids cleared.
REQ-028 Reset mid-CLEAR or mid-ACCUM SHALL abort immediately; RAM contents are not reset and are undefined after an abort.

Configuration
REQ-029 With PSUM_SATURATE_EN defined, an overflowing add SHALL clamp to the max/min signed DATA_WIDTH value.
REQ-030 Without PSUM_SATURATE_EN, the sum SHALL wrap modulo 2**DATA_WIDTH; status bit2 is set in both builds.

Structure
REQ-031 Package dnn_accel_pkg SHALL hold the FSM state enum and the ctrl/status bit index constants.
REQ-032 Storage SHALL be one sub-module, psum_sdp_ram: simple dual-port, 1-cycle synchronous read, DATA_WIDTH x 2**ADDR_WIDTH.

Verification
REQ-033 Clear: ADDR_WIDTH=4, pulse ctrl[8] -> busy for 16 cycles, then status=0x2; host read of every address -> 0.
REQ-034 Accumulate: beats (addr3,first,5),(addr3,7),(addr3,-2) back-to-back -> host read addr3 = 10 (forwarding).
REQ-035 Overflow: addr0=0x7FFFFFF0 then +0x20 -> status bit2=1; addr0=0x7FFFFFFF with macro, 0x80000010 without.
REQ-036 Drain: drop ctrl[0] in the cycle after the last beat -> acc_ready=0, busy for 2 more cycles, final write present.
REQ-037 Host latency: HOST, host_en at cycle t for addr5 -> host_rvalid at t+2 with addr5 data; host_en in IDLE -> no rvalid.
REQ-038 Reset: rst asserted mid-CLEAR at word 8 -> next cycle state IDLE, status=0, acc_ready=0.

Source files
------------

// File: rtl/dnn_accel_pkg.sv
// ============================================================================
// Module      : dnn_accel_pkg
// Description : Shared FSM state encoding and ctrl/status bit positions for
//               the psum accumulation buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dnn_accel_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    HOST  = 3'd4
  } psum_state_t;

  localparam int c_CTRL_ACC_EN   = 0;
  localparam int c_CTRL_HOST_RD  = 4;
  localparam int c_CTRL_CLR_REQ  = 8;

  localparam int c_STAT_BUSY     = 0;
  localparam int c_STAT_CLR_DONE = 1;
  localparam int c_STAT_OVF      = 2;

endpackage

`default_nettype wire

// File: rtl/psum_sdp_ram.sv
// ============================================================================
// Module      : psum_sdp_ram
// Description : Simple dual-port psum storage, one write port and one read
//               port with 1-cycle synchronous read (write-first on collision).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  // A read colliding with a write returns the new word, so a beat read two
  // cycles behind an in-progress write sees the updated value.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/psum_accum_buffer.sv
// ============================================================================
// Module      : psum_accum_buffer
// Description : Partial-sum accumulation buffer with clear, 3-stage
//               read-add-write pipeline, and host readback port.
//               Build option: PSUM_SATURATE_EN clamps overflowing adds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_accum_buffer
  import dnn_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
  output logic [REG_WIDTH-1:0]  o_conf_status,
  input  logic                  acc_valid,
  input  logic                  acc_first,
  input  logic [ADDR_WIDTH-1:0] acc_addr,
  input  logic [DATA_WIDTH-1:0] acc_data,
  output logic                  acc_ready,
  input  logic                  host_en,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid
);

  psum_state_t           r_state, w_state_nxt;
  logic                  r_clr_req_d, w_clr_edge;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  r_clr_done, r_ovf;
  logic                  r_s1_valid, r_s1_first;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_s2_valid, r_s2_first;
  logic [ADDR_WIDTH-1:0] r_s2_addr;
  logic [DATA_WIDTH-1:0] r_s2_data, r_s2_oper;
  logic                  r_host_pend, r_host_rvalid;
  logic [DATA_WIDTH-1:0] r_host_rdata;
  logic                  w_accept, w_host_rd, w_add_ovf, w_sum_ovf;
  logic [DATA_WIDTH-1:0] w_raw, w_add_res, w_s2_result;
  logic                  w_ram_we, w_ram_re;
  logic [ADDR_WIDTH-1:0] w_ram_waddr, w_ram_raddr;
  logic [DATA_WIDTH-1:0] w_ram_wdata, w_ram_rdata;
  logic                  w_unused_ctrl;

  assign w_unused_ctrl = ^i_conf_ctrl;
  assign w_clr_edge    = i_conf_ctrl[c_CTRL_CLR_REQ] & ~r_clr_req_d;
  assign w_accept      = (r_state == ACCUM) && acc_valid;
  assign w_host_rd     = (r_state == HOST) && host_en;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_clr_edge)                          w_state_nxt = CLEAR;
        else if (i_conf_ctrl[c_CTRL_HOST_RD])    w_state_nxt = HOST;
        else if (i_conf_ctrl[c_CTRL_ACC_EN])     w_state_nxt = ACCUM;
      end
      CLEAR:   if (r_clr_addr == '1)             w_state_nxt = IDLE;
      ACCUM:   if (!i_conf_ctrl[c_CTRL_ACC_EN])  w_state_nxt = DRAIN;
      // S2 retires at this edge, so only S1 keeps the drain open.
      DRAIN:   if (!r_s1_valid)                  w_state_nxt = IDLE;
      HOST: begin
        if (!i_conf_ctrl[c_CTRL_HOST_RD] && !w_host_rd && !r_host_pend)
          w_state_nxt = IDLE;
      end
      default:                                   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_req_d <= 1'b0;
      r_clr_addr  <= '0;
      r_clr_done  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_clr_req_d <= i_conf_ctrl[c_CTRL_CLR_REQ];
      if ((r_state == IDLE) && (w_state_nxt == CLEAR)) begin
        r_clr_addr <= '0;
        r_clr_done <= 1'b0;
        r_ovf      <= 1'b0;
      end else if (r_state == CLEAR) begin
        r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
        if (r_clr_addr == '1) r_clr_done <= 1'b1;
      end else if (w_sum_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
    end
  end

  // Forward the word S2 is writing when S1 targets the same address.
  always_ff @(posedge clk) begin
    r_s1_addr  <= acc_addr;
    r_s1_data  <= acc_data;
    r_s1_first <= acc_first;
    r_s2_addr  <= r_s1_addr;
    r_s2_data  <= r_s1_data;
    r_s2_first <= r_s1_first;
    r_s2_oper  <= (r_s2_valid && (r_s2_addr == r_s1_addr)) ? w_s2_result : w_ram_rdata;
  end

  assign w_raw     = r_s2_oper + r_s2_data;
  assign w_add_ovf = (r_s2_oper[DATA_WIDTH-1] == r_s2_data[DATA_WIDTH-1]) &&
                     (w_raw[DATA_WIDTH-1] != r_s2_oper[DATA_WIDTH-1]);

`ifdef PSUM_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] c_SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  assign w_add_res = w_add_ovf ? (r_s2_oper[DATA_WIDTH-1] ? c_SAT_MIN : c_SAT_MAX) : w_raw;
`else
  assign w_add_res = w_raw;
`endif

  assign w_s2_result = r_s2_first ? r_s2_data : w_add_res;
  assign w_sum_ovf   = r_s2_valid && !r_s2_first && w_add_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_host_pend   <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_host_pend   <= w_host_rd;
      r_host_rvalid <= r_host_pend;
      if (r_host_pend) r_host_rdata <= w_ram_rdata;
    end
  end

  assign w_ram_we    = (r_state == CLEAR) || r_s2_valid;
  assign w_ram_waddr = (r_state == CLEAR) ? r_clr_addr : r_s2_addr;
  assign w_ram_wdata = (r_state == CLEAR) ? '0 : w_s2_result;
  assign w_ram_re    = w_accept || w_host_rd;
  assign w_ram_raddr = (r_state == HOST) ? host_addr : acc_addr;

  psum_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    o_conf_status                  = '0;
    o_conf_status[c_STAT_BUSY]     = (r_state != IDLE);
    o_conf_status[c_STAT_CLR_DONE] = r_clr_done;
    o_conf_status[c_STAT_OVF]      = r_ovf;
  end

  assign acc_ready   = (r_state == ACCUM);
  assign host_rvalid = r_host_rvalid;
  assign host_rdata  = r_host_rdata;

endmodule

`default_nettype wire

// File: tb/tb_psum_accum_buffer.sv
// ============================================================================
// Module      : tb_psum_accum_buffer
// Description : Randomized scoreboard bench for psum_accum_buffer against a
//               word-array reference model (honours PSUM_SATURATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_accum_buffer;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int RW = 32;
  localparam int DEPTH = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] ctrl;
  logic [RW-1:0] status;
  logic          acc_valid, acc_first, acc_ready;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  logic          host_en, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_rdata;

  psum_accum_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .i_conf_ctrl(ctrl), .o_conf_status(status),
    .acc_valid(acc_valid), .acc_first(acc_first), .acc_addr(acc_addr),
    .acc_data(acc_data), .acc_ready(acc_ready), .host_en(host_en),
    .host_addr(host_addr), .host_rdata(host_rdata), .host_rvalid(host_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int due; int addr; } exp_t;
  typedef struct { int addr; bit first; logic [31:0] data; } beat_t;

  exp_t        sb[$];
  exp_t        mon_e;
  beat_t       bq[$];
  int          rd_q[$];
  logic [31:0] model_mem [DEPTH];
  bit          model_ovf;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                            output bit ovf);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    ovf = (s > MAXV) || (s < MINV);
`ifdef PSUM_SATURATE_EN
    if (s > MAXV) return 32'h7FFFFFFF;
    if (s < MINV) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every host response must match the head entry in data and cycle.
  always @(negedge clk) begin
    if (!rst && host_rvalid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h, required no response", host_rdata);
      end else begin
        mon_e = sb.pop_front();
        if (host_rdata !== mon_e.data || cyc != mon_e.due) begin
          fails++;
          $display("FAIL host_read[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                   mon_e.addr, host_rdata, cyc, mon_e.data, mon_e.due);
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    @(negedge clk);
    while (status[0] && n < bound) begin
      tick();
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, status[0]}, 32'd0);
    tick();
  endtask

  task automatic do_clear();
    int n = 0;
    ctrl = 32'h100;
    tick();
    ctrl = 32'h0;
    @(negedge clk);
    while (status[0] && n < 40) begin
      n++;
      tick();
      @(negedge clk);
    end
    check("clear_busy_cycles", n, 32'd16);
    check("clear_status", status, 32'h2);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_ovf = 1'b0;
    tick();
  endtask

  task automatic host_reads(input bit gaps);
    int n = 0;
    ctrl = 32'h10;
    tick();
    foreach (rd_q[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        host_en = 1'b0;
        tick();
      end
      host_en   = 1'b1;
      host_addr = AW'(rd_q[i]);
      sb.push_back('{model_mem[rd_q[i]], cyc + 2, rd_q[i]});
      tick();
    end
    host_en = 1'b0;
    ctrl    = 32'h0;
    wait_idle("host_exit", 6);
    while (sb.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    check("host_responses_pending", sb.size(), 32'd0);
    rd_q.delete();
  endtask

  task automatic read_all(input bit gaps);
    for (int i = 0; i < DEPTH; i++) rd_q.push_back(i);
    host_reads(gaps);
  endtask

  task automatic accum_burst(input bit gaps);
    bit o;
    ctrl = 32'h1;
    tick();
    foreach (bq[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        acc_valid = 1'b0;
        tick();
      end
      acc_valid = 1'b1;
      acc_addr  = AW'(bq[i].addr);
      acc_first = bq[i].first;
      acc_data  = bq[i].data;
      if (bq[i].first) model_mem[bq[i].addr] = bq[i].data;
      else begin
        model_mem[bq[i].addr] = model_add(model_mem[bq[i].addr], bq[i].data, o);
        if (o) model_ovf = 1'b1;
      end
      @(negedge clk);
      check("ready_in_accum", {31'd0, acc_ready}, 32'd1);
      tick();
    end
    acc_valid = 1'b0;
    ctrl      = 32'h0;
    tick();
    @(negedge clk);
    check("drain_ready", {31'd0, acc_ready}, 32'd0);
    check("drain_busy", {31'd0, status[0]}, 32'd1);
    tick();
    wait_idle("drain_exit", 1);
    check("ovf_sticky", {31'd0, status[2]}, {31'd0, model_ovf});
    bq.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a;
    rst = 1'b1; ctrl = '0; acc_valid = 1'b0; acc_first = 1'b0; acc_addr = '0;
    acc_data = '0; host_en = 1'b0; host_addr = '0;
    model_ovf = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_status", status, 32'h0);
    check("reset_ready", {31'd0, acc_ready}, 32'd0);
    check("reset_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("reset_rdata", host_rdata, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    do_clear();
    read_all(1'b0);

    // host_en outside HOST must be ignored
    host_en = 1'b1; host_addr = 4'd5;
    tick();
    host_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_rvalid", {31'd0, host_rvalid}, 32'd0);
      tick();
    end

    // back-to-back same-address beats rely on forwarding
    bq.push_back('{3, 1'b1, 32'd5});
    bq.push_back('{3, 1'b0, 32'd7});
    bq.push_back('{3, 1'b0, -32'sd2});
    accum_burst(1'b0);
    rd_q.push_back(3);
    rd_q.push_back(5);
    host_reads(1'b0);

    // signed overflow at addr0
    do_clear();
    bq.push_back('{0, 1'b1, 32'h7FFFFFF0});
    bq.push_back('{0, 1'b0, 32'h00000020});
    accum_burst(1'b0);
    check("ovf_status_bit", {31'd0, status[2]}, 32'd1);
    rd_q.push_back(0);
    host_reads(1'b0);

    // randomized sessions
    for (int r = 0; r < 6; r++) begin
      a = $urandom_range(0, DEPTH - 1);
      for (int b = 0; b < 24; b++) begin
        if ($urandom_range(0, 1) == 0) a = $urandom_range(0, DEPTH - 1);
        bq.push_back('{a, ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                                   : 32'($urandom_range(0, 2000)) - 32'd1000});
      end
      accum_burst(r[0]);
      read_all(1'b1);
    end

    // reset in the middle of a clear, at word 8
    ctrl = 32'h100;
    tick();
    ctrl = 32'h0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("abort_status", status, 32'h0);
    check("abort_ready", {31'd0, acc_ready}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_clear();
    read_all(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
